// File: rtl/imem_port_arbiter.sv
// Shares one 2-cycle pipelined memory port between fetch and data; IMEM_ARB_PERF_EN adds a fetch-stall counter.
// Latency: grant is combinational, read data returns two enabled cycles after issue.
// Backpressure: the losing requester simply sees no grant; clk_en low freezes all state.
module imem_port_arbiter #(
    parameter int MAX_DSTREAK = 3,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_kill,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [29:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fstall_cnt
`endif
);

    typedef struct packed {
        logic vld;
        logic own_f;
        logic killed;
    } tag_t;

    localparam logic [3:0] MAXS = 4'(MAX_DSTREAK);

    tag_t       s1, s2;
    logic [3:0] streak;
    logic       act;
    logic       f_elig;
    logic       at_max;
    logic       rd_issue;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^{f_addr[1:0], d_addr[1:0]};

    // Reset gates the combinational outputs too, so nothing escapes while rst_n is low.
    assign act    = clk_en & rst_n;
    assign f_elig = f_req & ~f_kill;
    assign at_max = (streak == MAXS);

    assign d_gnt = act & d_req & ~(f_elig & at_max);
    assign f_gnt = act & f_elig & (~d_req | at_max);

    assign mem_en    = f_gnt | d_gnt;
    assign mem_addr  = d_gnt ? d_addr[31:2] : (f_gnt ? f_addr[31:2] : 30'h0);
    assign mem_we    = (d_gnt & d_we) ? d_be : 4'h0;
    assign mem_wdata = d_gnt ? d_wdata : 32'h0;
    assign rd_issue  = f_gnt | (d_gnt & ~d_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else if (clk_en) begin
            s1.vld    <= rd_issue;
            s1.own_f  <= f_gnt;
            s1.killed <= 1'b0;
            s2.vld    <= s1.vld;
            s2.own_f  <= s1.own_f;
            // A kill this cycle catches the fetch that is one stage behind.
            s2.killed <= s1.killed | (f_kill & s1.own_f);
        end
    end

    // The stage2 fetch is dropped in the kill cycle itself.
    assign f_rvalid = act & s2.vld & s2.own_f & ~s2.killed & ~f_kill;
    assign d_rvalid = act & s2.vld & ~s2.own_f;
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 4'h0;
        end else if (clk_en) begin
            if (f_gnt || !f_elig)
                streak <= 4'h0;
            else if (d_gnt && !at_max)
                streak <= streak + 4'h1;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_fstall_cnt <= '0;
        else if (clk_en && f_elig && !f_gnt)
            perf_fstall_cnt <= perf_fstall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: grants checked inline, read responses checked against queues.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_kill = 1'b0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf;
`endif

    imem_port_arbiter #(.MAX_DSTREAK(3), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
        , .perf_fstall_cnt(perf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    exp_t fq[$];
    exp_t dq[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    bit   ef, ed;

    // Memory model: echoes the issued word address as byte address two enabled cycles later.
    logic [29:0] p1 = 30'h0;
    logic [29:0] p2 = 30'h0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clk_en) begin
            p1 <= mem_en ? mem_addr : 30'h0;
            p2 <= p1;
        end
    end
    assign mem_rdata = {p2, 2'b00};

    always @(negedge clk) begin
        if (mon_on) begin
            ef = (fq.size() > 0) && (fq[0].due == cyc);
            ed = (dq.size() > 0) && (dq[0].due == cyc);
            nvec++;
            if (f_rvalid !== ef) begin
                nerr++;
                $display("FAIL f_rvalid cyc=%0d got %b want %b", cyc, f_rvalid, ef);
            end
            if (ef) begin
                nvec++;
                if (f_rdata !== fq[0].dat) begin
                    nerr++;
                    $display("FAIL f_rdata cyc=%0d got %h want %h", cyc, f_rdata, fq[0].dat);
                end
                void'(fq.pop_front());
            end
            nvec++;
            if (d_rvalid !== ed) begin
                nerr++;
                $display("FAIL d_rvalid cyc=%0d got %b want %b", cyc, d_rvalid, ed);
            end
            if (ed) begin
                nvec++;
                if (d_rdata !== dq[0].dat) begin
                    nerr++;
                    $display("FAIL d_rdata cyc=%0d got %h want %h", cyc, d_rdata, dq[0].dat);
                end
                void'(dq.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            f_req = 1'b0; d_req = 1'b0; f_kill = 1'b0; d_we = 1'b0; d_be = 4'h0;
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1; f_req = 1'b1; d_req = 1'b1; f_addr = 32'h10; d_addr = 32'h20;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++;
            if ({f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid, mem_we, mem_addr, mem_wdata} !== '0) begin
                nerr++;
                $display("FAIL reset_outputs got gnt=%b%b en=%b addr=%h want all zero", f_gnt, d_gnt, mem_en, mem_addr);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        nvec++;
        if ({f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid} !== 5'b0) begin
            nerr++;
            $display("FAIL post_reset_idle got %b want 00000", {f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid});
        end
`ifdef IMEM_ARB_PERF_EN
        nvec++;
        if (perf !== 32'd0) begin
            nerr++;
            $display("FAIL perf_reset got %0d want 0", perf);
        end
`endif
        mon_on = 1'b1;
    endtask

    task automatic test_fetch_stream();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'h400 + 32'(4 * i);
            @(posedge clk); #1;
            f_req = 1'b1; f_addr = a;
            @(negedge clk);
            nvec++;
            if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== a[31:2] || mem_we !== 4'h0) begin
                nerr++;
                $display("FAIL fetch_issue%0d got gnt=%b%b addr=%h we=%h want 10 %h 0", i, f_gnt, d_gnt, mem_addr, mem_we, a[31:2]);
            end
            fq.push_back('{cyc + 2, a});
        end
        idle(3);
    endtask

    task automatic test_contention();
        logic [31:0] fa, da;
        bit          wf;
        for (int i = 0; i < 12; i++) begin
            fa = 32'h600 + 32'(4 * i);
            da = 32'h2000 + 32'(4 * i);
            wf = (i % 4 == 3);
            @(posedge clk); #1;
            f_req = 1'b1; f_addr = fa; d_req = 1'b1; d_we = 1'b0; d_addr = da;
            @(negedge clk);
            nvec++;
            if (f_gnt !== wf || d_gnt !== !wf || mem_addr !== (wf ? fa[31:2] : da[31:2]) || mem_we !== 4'h0) begin
                nerr++;
                $display("FAIL contend%0d got gnt=%b%b addr=%h want fetch=%b", i, f_gnt, d_gnt, mem_addr, wf);
            end
            if (wf) fq.push_back('{cyc + 2, fa});
            else    dq.push_back('{cyc + 2, da});
        end
        @(posedge clk); #1;
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
        nvec++;
        if (perf !== 32'd9) begin
            nerr++;
            $display("FAIL perf_contend got %0d want 9", perf);
        end
`endif
        idle(2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clk_en = 1'b0; f_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            nvec++;
            if ({f_gnt, d_gnt, mem_en} !== 3'b0) begin
                nerr++;
                $display("FAIL clk_en_freeze%0d got %b want 000", i, {f_gnt, d_gnt, mem_en});
            end
`ifdef IMEM_ARB_PERF_EN
            nvec++;
            if (perf !== 32'd9) begin
                nerr++;
                $display("FAIL perf_frozen%0d got %0d want 9", i, perf);
            end
`endif
        end
        @(posedge clk); #1;
        clk_en = 1'b1; f_req = 1'b0; d_req = 1'b0;
        idle(1);
    endtask

    task automatic test_kill();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            f_req = 1'b1; f_addr = 32'h500 + 32'(4 * i);
            @(negedge clk);
            nvec++;
            if (f_gnt !== 1'b1) begin
                nerr++;
                $display("FAIL kill_prefetch%0d got f_gnt=%b want 1", i, f_gnt);
            end
        end
        @(posedge clk); #1;
        f_kill = 1'b1; f_addr = 32'h508; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        @(negedge clk);
        nvec++;
        if (f_gnt !== 1'b0 || d_gnt !== 1'b1 || f_rvalid !== 1'b0) begin
            nerr++;
            $display("FAIL kill_cycle got f_gnt=%b d_gnt=%b f_rvalid=%b want 0 1 0", f_gnt, d_gnt, f_rvalid);
        end
        dq.push_back('{cyc + 2, 32'h3000});
        idle(4);
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1008; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        nvec++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 30'h402 || mem_wdata !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL write_issue got gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 0011 402 deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        bit          isf;
        for (int i = 0; i < 8; i++) begin
            isf = (i % 2 == 0);
            a = isf ? 32'h700 + 32'(4 * i) : 32'h4000 + 32'(4 * i);
            @(posedge clk); #1;
            f_req = isf; f_addr = a; d_req = !isf; d_we = 1'b0; d_addr = a;
            @(negedge clk);
            nvec++;
            if (mem_en !== 1'b1 || f_gnt !== isf || d_gnt !== !isf || mem_addr !== a[31:2]) begin
                nerr++;
                $display("FAIL b2b%0d got en=%b gnt=%b%b addr=%h want %h", i, mem_en, f_gnt, d_gnt, mem_addr, a[31:2]);
            end
            if (isf) fq.push_back('{cyc + 2, a});
            else     dq.push_back('{cyc + 2, a});
        end
        idle(3);
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 32'h800;
        @(posedge clk); #1;
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1;
            @(negedge clk);
            nvec++;
            if ({f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid, mem_we, mem_addr, mem_wdata} !== '0) begin
                nerr++;
                $display("FAIL reset_inflight%0d got gnt=%b%b en=%b rv=%b%b want all zero", i, f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
        nvec++;
        if (perf !== 32'd0) begin
            nerr++;
            $display("FAIL perf_after_reset got %0d want 0", perf);
        end
`endif
        idle(4);
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_contention();
        test_kill();
        test_write();
        test_back_to_back();
        test_reset_inflight();
        idle(2);
        nvec++;
        if (fq.size() != 0 || dq.size() != 0) begin
            nerr++;
            $display("FAIL pending_responses got f=%0d d=%0d want 0 0", fq.size(), dq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
